uart_tx_engine: RTL and testbench

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_baud_gen.sv | 48 ++++
 rtl/uart_tx_engine.sv | 143 ++++++++++++++
 tb/tb_uart_tx_engine.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: baud table, frame-format encodings and FSM states.
// Imported by uart_baud_gen and uart_tx_engine so the encodings live in one place.
package uart_pkg;

    localparam int BAUD_TABLE [8] = '{9600, 19200, 38400, 57600,
                                      115200, 230400, 460800, 921600};

    localparam logic [1:0] LEN_5 = 2'b00;
    localparam logic [1:0] LEN_6 = 2'b01;
    localparam logic [1:0] LEN_7 = 2'b10;
    localparam logic [1:0] LEN_8 = 2'b11;

    localparam logic [1:0] PAR_NONE     = 2'b00;
    localparam logic [1:0] PAR_ODD      = 2'b01;
    localparam logic [1:0] PAR_EVEN     = 2'b10;
    localparam logic [1:0] PAR_NONE_ALT = 2'b11;

    localparam logic STOP_1 = 1'b0;
    localparam logic STOP_2 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    function automatic logic [3:0] data_bits(input logic [1:0] len);
        return 4'd5 + {2'b00, len};
    endfunction

    function automatic logic parity_enabled(input logic [1:0] par);
        return (par == PAR_ODD) || (par == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: divisor latched from the baud table on restart, tick on the last cycle of each period.
// Tick is combinational from the count register; no backpressure, counter idles at 0 while disabled.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int INTERNAL_CLK = 125_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] baud_sel,
    input  logic       restart,
    input  logic       en,
    output logic       tick
);

    localparam int CNT_W = $clog2(INTERNAL_CLK / BAUD_TABLE[0] + 1);

    logic [CNT_W-1:0] div_tab [8];
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] cnt;

    // Rates the clock cannot reach are pinned to the fastest legal divisor of 2;
    // a clock too slow even for the lowest rate is refused outright.
    for (genvar g = 0; g < 8; g++) begin : g_tab
        localparam int D = INTERNAL_CLK / BAUD_TABLE[g];
        if (g == 0 && D < 2) begin : g_too_slow
            $error("uart_baud_gen: INTERNAL_CLK too low, divisor below 2");
        end
        assign div_tab[g] = CNT_W'((D < 2) ? 2 : D);
    end

    assign tick = en && (cnt == (div_q - CNT_W'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            div_q <= '0;
        end else if (restart) begin
            cnt   <= '0;
            div_q <= div_tab[baud_sel];
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: tx low one cycle after accept, ready again the cycle after the last stop bit.
// Optional line break behind UART_TX_BREAK_EN; backpressure via registered tx_data_rdy (IDLE only).
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int INTERNAL_CLK = 125_000_000,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        baud_mux_tx,
    input  logic [1:0]        data_len_tx,
    input  logic              stop_len_tx,
    input  logic [1:0]        parity_tx,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_data_vld,
`ifdef UART_TX_BREAK_EN
    input  logic              tx_break,
`endif
    output logic              tx_data_rdy,
    output logic              tx,
    output logic              tx_busy
);

    tx_state_t         state;
    logic [DATA_W-1:0] shreg;
    logic [3:0]        bits_left;
    logic              par_en;
    logic              par_bit;
    logic              stop2;
    logic              stop_second;
    logic              accept;
    logic              tick;
    logic              idle_level;
    logic [3:0]        nbits;
    logic [DATA_W-1:0] masked;

`ifdef UART_TX_BREAK_EN
    assign accept     = tx_data_vld && tx_data_rdy && !tx_break;
    assign idle_level = !tx_break;
`else
    assign accept     = tx_data_vld && tx_data_rdy;
    assign idle_level = 1'b1;
`endif

    always_comb begin
        nbits  = data_bits(data_len_tx);
        masked = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < int'(nbits)) masked[i] = tx_data[i];
        end
    end

    uart_baud_gen #(
        .INTERNAL_CLK(INTERNAL_CLK)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .baud_sel(baud_mux_tx),
        .restart (accept),
        .en      (tx_busy),
        .tick    (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            tx          <= 1'b1;
            tx_data_rdy <= 1'b0;
            tx_busy     <= 1'b0;
            shreg       <= '0;
            bits_left   <= '0;
            par_en      <= 1'b0;
            par_bit     <= 1'b0;
            stop2       <= 1'b0;
            stop_second <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state       <= ST_START;
                        tx          <= 1'b0;
                        tx_data_rdy <= 1'b0;
                        tx_busy     <= 1'b1;
                        shreg       <= masked;
                        bits_left   <= nbits - 4'd1;
                        par_en      <= parity_enabled(parity_tx);
                        par_bit     <= (parity_tx == PAR_ODD) ? ~(^masked) : ^masked;
                        stop2       <= (stop_len_tx == STOP_2);
                        stop_second <= 1'b0;
                    end else begin
                        tx          <= idle_level;
                        tx_data_rdy <= idle_level;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state <= ST_DATA;
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bits_left == 4'd0) begin
                            state <= par_en ? ST_PARITY : ST_STOP;
                            tx    <= par_en ? par_bit : 1'b1;
                        end else begin
                            bits_left <= bits_left - 4'd1;
                            tx        <= shreg[0];
                            shreg     <= shreg >> 1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        state <= ST_STOP;
                        tx    <= 1'b1;
                    end
                end
                ST_STOP: begin
                    // A second stop period reuses the same state; a pending break only shows once back in IDLE.
                    if (tick) begin
                        if (stop2 && !stop_second) begin
                            stop_second <= 1'b1;
                        end else begin
                            state       <= ST_IDLE;
                            tx_busy     <= 1'b0;
                            tx          <= idle_level;
                            tx_data_rdy <= idle_level;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: expected line segments are queued per frame and checked cycle by cycle.
module tb_uart_tx_engine;

    localparam int CLK_HZ = 1_152_000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] baud_mux_tx = 3'd4;
    logic [1:0] data_len_tx = 2'b11;
    logic       stop_len_tx = 1'b0;
    logic [1:0] parity_tx   = 2'b00;
    logic [7:0] tx_data     = 8'h00;
    logic       tx_data_vld = 1'b0;
    logic       tx_data_rdy;
    logic       tx;
    logic       tx_busy;
`ifdef UART_TX_BREAK_EN
    logic       tx_break = 1'b0;
`endif

    typedef struct {
        logic lvl;
        int   cycles;
    } seg_t;

    seg_t sb[$];
    int   rates [8] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600};
    int   errors = 0;
    int   checks = 0;

    uart_tx_engine #(
        .INTERNAL_CLK(CLK_HZ),
        .DATA_W      (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_mux_tx(baud_mux_tx),
        .data_len_tx(data_len_tx),
        .stop_len_tx(stop_len_tx),
        .parity_tx  (parity_tx),
        .tx_data    (tx_data),
        .tx_data_vld(tx_data_vld),
`ifdef UART_TX_BREAK_EN
        .tx_break   (tx_break),
`endif
        .tx_data_rdy(tx_data_rdy),
        .tx         (tx),
        .tx_busy    (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: start, low len bits LSB first, optional parity, stop bits.
    function automatic void push_frame(input logic [7:0] d, input logic [1:0] len,
                                       input logic stp, input logic [1:0] par, input logic [2:0] bsel);
        int   div;
        int   nb;
        int   ones;
        logic p;
        div  = CLK_HZ / rates[bsel];
        nb   = 5 + int'(len);
        ones = 0;
        sb.push_back('{1'b0, div});
        for (int i = 0; i < nb; i++) begin
            sb.push_back('{d[i], div});
            ones += int'(d[i]);
        end
        if (par == 2'b01 || par == 2'b10) begin
            p = (par == 2'b01) ? ((ones % 2) == 0) : ((ones % 2) == 1);
            sb.push_back('{p, div});
        end
        sb.push_back('{1'b1, stp ? 2 * div : div});
    endfunction

    task automatic send(input logic [7:0] d, input logic [1:0] len, input logic stp,
                        input logic [1:0] par, input logic [2:0] bsel, input int exp_total,
                        input bit chain, input string tag);
        int   n;
        int   idx;
        int   busy_cycles;
        bit   ok;
        seg_t s;
        push_frame(d, len, stp, par, bsel);
        if (!chain) @(negedge clk);
        tx_data     = d;
        data_len_tx = len;
        stop_len_tx = stp;
        parity_tx   = par;
        baud_mux_tx = bsel;
        tx_data_vld = 1'b1;
        n = 0;
        while (tx_data_rdy !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rdy_before_accept"}, {31'd0, tx_data_rdy}, 32'd1);
        if (tx_data_rdy !== 1'b1) begin
            tx_data_vld = 1'b0;
            sb.delete();
            return;
        end
        @(posedge clk);
        #1 tx_data_vld = 1'b0;
        idx = 0;
        busy_cycles = 0;
        while (sb.size() > 0) begin
            s  = sb.pop_front();
            ok = 1'b1;
            for (int k = 0; k < s.cycles; k++) begin
                @(negedge clk);
                if (tx !== s.lvl) ok = 1'b0;
                if (tx_data_rdy !== 1'b0) ok = 1'b0;
                if (tx_busy === 1'b1) busy_cycles++;
            end
            check($sformatf("%s_seg%0d", tag, idx), {31'd0, ok}, 32'd1);
            idx++;
        end
        @(negedge clk);
        check({tag, "_rdy_after"}, {31'd0, tx_data_rdy}, 32'd1);
        check({tag, "_busy_after"}, {31'd0, tx_busy}, 32'd0);
        check({tag, "_tx_gap"}, {31'd0, tx}, 32'd1);
        check({tag, "_frame_cycles"}, busy_cycles, exp_total);
    endtask

    initial begin
        bit ok;

        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_rdy", {31'd0, tx_data_rdy}, 32'd0);
        check("reset_busy", {31'd0, tx_busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rdy_after_release", {31'd0, tx_data_rdy}, 32'd1);

        send(8'h55, 2'b11, 1'b0, 2'b00, 3'd4, 100, 1'b0, "f55_8N1");
        send(8'h41, 2'b10, 1'b1, 2'b10, 3'd4, 110, 1'b1, "f41_7E2_b2b");
        send(8'hFF, 2'b00, 1'b0, 2'b01, 3'd4, 80, 1'b0, "fFF_5O1");

        fork
            send(8'hA5, 2'b11, 1'b0, 2'b00, 3'd4, 100, 1'b0, "fA5_midchange");
            begin
                repeat (31) @(negedge clk);
                baud_mux_tx = 3'd0;
                parity_tx   = 2'b10;
            end
        join
        send(8'h3C, 2'b11, 1'b0, 2'b10, 3'd0, 1320, 1'b0, "f3C_8E1_9600");

        @(negedge clk);
        tx_data = 8'h55; data_len_tx = 2'b11; stop_len_tx = 1'b0;
        parity_tx = 2'b00; baud_mux_tx = 3'd4; tx_data_vld = 1'b1;
        @(posedge clk);
        #1 tx_data_vld = 1'b0;
        repeat (45) @(negedge clk);
        check("midframe_tx_before_rst", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        #1;
        check("midframe_rst_tx", {31'd0, tx}, 32'd1);
        check("midframe_rst_busy", {31'd0, tx_busy}, 32'd0);
        check("midframe_rst_rdy", {31'd0, tx_data_rdy}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rdy_after_midframe_rst", {31'd0, tx_data_rdy}, 32'd1);
        send(8'h96, 2'b11, 1'b0, 2'b01, 3'd4, 110, 1'b0, "f96_8O1_post_rst");

`ifdef UART_TX_BREAK_EN
        @(negedge clk);
        tx_break = 1'b1;
        tx_data = 8'h5A; data_len_tx = 2'b11; stop_len_tx = 1'b0;
        parity_tx = 2'b00; baud_mux_tx = 3'd4; tx_data_vld = 1'b1;
        ok = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (tx !== 1'b0 || tx_data_rdy !== 1'b0 || tx_busy !== 1'b0) ok = 1'b0;
        end
        check("break_hold", {31'd0, ok}, 32'd1);
        tx_break = 1'b0;
        send(8'h5A, 2'b11, 1'b0, 2'b00, 3'd4, 100, 1'b0, "f5A_after_break");
`else
        ok = 1'b1;
        check("no_break_idle_tx", {31'd0, tx}, {31'd0, ok});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
